ref_block_loader: RTL and testbench
===================================

Name: ref_block_loader

Overview:
- Upstream feeder for the subpixel interpolation stage.
- Assembles a (BLK+TAPS-1)x(BLK+TAPS-1) reference window from a row-per-beat valid/ready stream into the flat 1800-bit buffer the interpolator consumes.
- Holds each completed window stable until the consumer acknowledges it.
- Counts delivered blocks.

Parameters:
- PIX_W, 8, bits per pixel
- BLK, 8, output block edge in pixels
- TAPS, 8, FIR tap count; the window edge DIM = BLK+TAPS-1 = 15
- CNT_W, 16, width of the delivered-block counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  row beat valid
- in_ready  out  1  loader can accept a row
- in_row  in  DIM*PIX_W (120)  one window row; pixel c at [c*PIX_W +: PIX_W]
- flush  in  1  discard the partially filled window
- out_valid  out  1  out_buffer holds a complete window
- out_ready  in  1  consumer accepts the window
- out_buffer  out  DIM*DIM*PIX_W (1800)  row r at [r*DIM*PIX_W +: DIM*PIX_W]
- out_sof  out  1  one-cycle pulse on the first cycle out_valid is high for a new window (interpolator start)
- blk_cnt  out  CNT_W  windows delivered, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async): state=S_FILL, row_cnt=0, out_valid=0, out_sof=0, blk_cnt=0, out_buffer=0, in_ready=1 on the first cycle after release.
- States (single buffer): S_FILL and S_FULL.
- S_FILL:
  - in_ready=1.
  - An accept (in_valid&&in_ready) writes in_row to row row_cnt, then row_cnt++.
  - An accept at row_cnt=DIM-1 moves to S_FULL.
  - out_valid=1 and out_sof=1 on the next cycle (1-cycle latency from the last row).
- S_FULL:
  - in_ready=0; out_buffer is frozen.
  - out_valid&&out_ready increments blk_cnt and returns to S_FILL with row_cnt=0.
  - out_valid falls the next cycle and in_ready rises the next cycle; there is no same-cycle bypass.
- out_sof is high exactly one cycle per window, even if out_ready is held high throughout.
- flush:
  - In S_FILL, row_cnt=0 next cycle and the partial rows are ignored. Stale data stays in storage but is overwritten before the window completes.
  - flush with a simultaneous accept: flush wins and the row is dropped.
  - In S_FULL (single buffer), flush is ignored; a completed window is never dropped.
- in_valid without in_ready: no state change; in_row is ignored.
- out_ready without out_valid: ignored; blk_cnt unchanged.
- blk_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-fill or mid-hold: immediate return to reset values; any window is lost.

Optional Feature:
- Macro: REF_LOADER_DOUBLE_BUF_EN.
- Enabled:
  - Two banks (ping-pong), with a fill pointer and a read pointer.
  - in_ready=1 whenever the fill bank is not complete.
  - When the fill bank completes and the other bank is free (or freed in the same cycle by out_valid&&out_ready), the fill and read pointers swap and filling continues without a bubble.
  - If both banks are full, in_ready=0.
  - flush affects only the fill bank.
  - out_valid, out_sof and blk_cnt semantics are unchanged; windows are delivered strictly in order.
- Disabled: single-buffer behaviour as above; there is no second bank.

Decomposition:
- Package ref_loader_pkg holds:
  - state encoding (S_FILL=1'b0, S_FULL=1'b1)
  - DIM, ROW_W=DIM*PIX_W, BUF_W=DIM*ROW_W
  - row_cnt width = clog2(DIM) = 4
- One natural sub-module, window_bank:
  - DIM x ROW_W row storage with write-enable and row index.
  - Flat BUF_W read-out.
  - Instantiated once, or twice under REF_LOADER_DOUBLE_BUF_EN.

Test Plan:
- Reset, then 15 back-to-back rows with row r pixel c = r*16+c -> out_valid=1 and out_sof=1 one cycle after row 14. out_buffer[7:0]=0x00, out_buffer[1799:1792]=0xEE. blk_cnt=0.
- Hold out_ready=0 for 20 cycles after full -> in_ready=0, out_buffer unchanged, out_sof high only on the first cycle. Then out_ready=1 for one cycle -> blk_cnt=1, out_valid=0 and in_ready=1 the next cycle.
- Load 6 rows, pulse flush with in_valid=1, then send 15 rows of 0xAA -> the flushed row is dropped and the window is all 0xAA.
- Assert rst low mid-fill (row 9) and mid-hold -> all outputs return to reset values asynchronously. A subsequent full load behaves as in the first test.
- Continuous stream of 3 windows with out_ready tied high:
  - single buffer: one bubble per window.
  - REF_LOADER_DOUBLE_BUF_EN: in_ready stays high after the first window.
  - Both: blk_cnt=3, windows delivered in order.
- CNT_W=2, deliver 5 windows -> blk_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ref_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ref_loader_pkg
//  Description : Shared types and default geometry for the reference block
//                loader. The window edge is DIM = BLK + TAPS - 1; the default
//                constants below describe the 8x8 block / 8-tap build
//                (15x15 window of 8-bit pixels).
//  Revision    : 1.0 - initial release
// ============================================================================
package ref_loader_pkg;

    localparam int PIX_W_DFLT = 8;
    localparam int BLK_DFLT   = 8;
    localparam int TAPS_DFLT  = 8;

    localparam int DIM        = BLK_DFLT + TAPS_DFLT - 1;
    localparam int ROW_W      = DIM * PIX_W_DFLT;
    localparam int BUF_W      = DIM * ROW_W;
    localparam int ROW_CNT_W  = $clog2(DIM);

    // Per-bank fill state: a bank is either collecting rows or holding a
    // complete window for the consumer.
    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    // Window edge needed to run a TAPS-tap filter over a BLK-wide block.
    function automatic int win_dim(input int blk, input int taps);
        return blk + taps - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_block_loader_window_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ref_block_loader_window_bank
//  Description : DIM rows of ROW_W-bit storage written one row at a time and
//                read out as one flat DIM*ROW_W vector (row r at
//                [r*ROW_W +: ROW_W]).
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low; clears storage
//                i_we       - write the row selected by i_row_idx
//                i_row_idx  - destination row index
//                i_row_data - row contents
//                o_buffer   - flat read-out of all rows
//  Revision    : 1.0 - initial release
// ============================================================================
module ref_block_loader_window_bank #(
    parameter int DIM    = 15,
    parameter int ROW_W  = 120,
    parameter int RCNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [RCNT_W-1:0]    i_row_idx,
    input  logic [ROW_W-1:0]     i_row_data,
    output logic [DIM*ROW_W-1:0] o_buffer
);

    for (genvar gr = 0; gr < DIM; gr++) begin : g_row
        logic [ROW_W-1:0] r_row;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_row <= '0;
            end else if (i_we && (i_row_idx == RCNT_W'(gr))) begin
                r_row <= i_row_data;
            end
        end

        assign o_buffer[gr*ROW_W +: ROW_W] = r_row;
    end

endmodule
`default_nettype wire

// File: rtl/ref_block_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ref_block_loader
//  Description : Collects one window row per valid/ready beat into a
//                DIM x DIM pixel reference window (DIM = BLK+TAPS-1), presents
//                the complete window to the interpolator and holds it until
//                accepted, and counts delivered windows.
//  Build macro : REF_LOADER_DOUBLE_BUF_EN - ping-pong pair of window banks so
//                the next window fills while the previous one is held.
//                Undefined: a single bank; input stalls while a window is held.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low
//                in_valid   - row beat valid
//                in_ready   - loader can accept a row
//                in_row     - one row; pixel c at [c*PIX_W +: PIX_W]
//                flush      - discard the partially filled window
//                out_valid  - out_buffer holds a complete window
//                out_ready  - consumer accepts the window
//                out_buffer - window; row r at [r*DIM*PIX_W +: DIM*PIX_W]
//                out_sof    - pulse on the first valid cycle of each window
//                blk_cnt    - delivered windows, wraps modulo 2^CNT_W
//  Revision    : 1.0 - initial release
// ============================================================================
module ref_block_loader
    import ref_loader_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int BLK   = 8,
    parameter int TAPS  = 8,
    parameter int CNT_W = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [(BLK+TAPS-1)*PIX_W-1:0]                 in_row,
    input  logic                                          flush,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [(BLK+TAPS-1)*(BLK+TAPS-1)*PIX_W-1:0]    out_buffer,
    output logic                                          out_sof,
    output logic [CNT_W-1:0]                              blk_cnt
);

    localparam int c_dim    = win_dim(BLK, TAPS);
    localparam int c_row_w  = c_dim * PIX_W;
    localparam int c_buf_w  = c_dim * c_row_w;
    localparam int c_rcnt_w = $clog2(c_dim);
`ifdef REF_LOADER_DOUBLE_BUF_EN
    localparam int c_nbank  = 2;
`else
    localparam int c_nbank  = 1;
`endif
    localparam logic [c_rcnt_w-1:0] c_last_row = c_rcnt_w'(c_dim - 1);

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_wr;
    logic                 w_last;
    logic                 w_pop;
    logic                 w_sof_nxt;
    logic [c_nbank-1:0]   w_bank_we;
    logic [c_buf_w-1:0]   w_bank_buf [c_nbank];
    logic [c_rcnt_w-1:0]  r_row_cnt;
    logic                 r_out_sof;
    logic [CNT_W-1:0]     r_blk_cnt;

    // flush takes priority over a simultaneous row beat, which is dropped.
    assign w_wr   = in_valid & w_in_ready & ~flush;
    assign w_last = w_wr & (r_row_cnt == c_last_row);
    assign w_pop  = w_out_valid & out_ready;

`ifdef REF_LOADER_DOUBLE_BUF_EN
    // Ping-pong: rows go to the bank at r_fill_ptr, the consumer sees the bank
    // at r_rd_ptr. Windows complete and are consumed alternately, so the two
    // pointers toggling independently keeps delivery in order.
    state_t r_bank_state [2];
    state_t w_bank_nxt   [2];
    logic   r_fill_ptr;
    logic   r_rd_ptr;
    logic   w_fill_ptr_nxt;
    logic   w_rd_ptr_nxt;

    assign w_in_ready  = (r_bank_state[r_fill_ptr] == S_FILL);
    assign w_out_valid = (r_bank_state[r_rd_ptr] == S_FULL);
    assign w_bank_we   = {w_wr & r_fill_ptr, w_wr & ~r_fill_ptr};
    assign out_buffer  = w_bank_buf[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank_state[0] <= S_FILL;
            r_bank_state[1] <= S_FILL;
            r_fill_ptr      <= 1'b0;
            r_rd_ptr        <= 1'b0;
        end else begin
            r_bank_state[0] <= w_bank_nxt[0];
            r_bank_state[1] <= w_bank_nxt[1];
            r_fill_ptr      <= w_fill_ptr_nxt;
            r_rd_ptr        <= w_rd_ptr_nxt;
        end
    end

    always_comb begin
        w_bank_nxt[0]  = r_bank_state[0];
        w_bank_nxt[1]  = r_bank_state[1];
        w_fill_ptr_nxt = r_fill_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        if (w_pop) begin
            w_bank_nxt[r_rd_ptr] = S_FULL == S_FULL ? S_FILL : S_FILL;
            w_rd_ptr_nxt         = ~r_rd_ptr;
        end
        if (w_last) begin
            w_bank_nxt[r_fill_ptr] = S_FULL;
        end
        // Move filling to the other bank once the current one is complete and
        // the other one is free, counting a bank released by this cycle's pop.
        if ((w_last || !w_in_ready) && (w_bank_nxt[~r_fill_ptr] == S_FILL)) begin
            w_fill_ptr_nxt = ~r_fill_ptr;
        end
        // A new window appears either from idle or straight after a pop.
        w_sof_nxt = (w_bank_nxt[w_rd_ptr_nxt] == S_FULL) && (w_pop || !w_out_valid);
    end
`else
    state_t r_state;
    state_t w_state_nxt;

    assign w_in_ready  = (r_state == S_FILL);
    assign w_out_valid = (r_state == S_FULL);
    assign w_bank_we   = w_wr;
    assign out_buffer  = w_bank_buf[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sof_nxt   = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_last) begin
                    w_state_nxt = S_FULL;
                    w_sof_nxt   = 1'b1;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end
`endif

    // The row index belongs to the bank being filled; a completed bank is
    // always restarted at row 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_cnt <= '0;
        end else if (flush || w_last) begin
            r_row_cnt <= '0;
        end else if (w_wr) begin
            r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_sof <= 1'b0;
            r_blk_cnt <= '0;
        end else begin
            r_out_sof <= w_sof_nxt;
            if (w_pop) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    for (genvar gb = 0; gb < c_nbank; gb++) begin : g_bank
        ref_block_loader_window_bank #(
            .DIM    (c_dim),
            .ROW_W  (c_row_w),
            .RCNT_W (c_rcnt_w)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_we       (w_bank_we[gb]),
            .i_row_idx  (r_row_cnt),
            .i_row_data (in_row),
            .o_buffer   (w_bank_buf[gb])
        );
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_sof   = r_out_sof;
    assign blk_cnt   = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ref_block_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ref_block_loader
//  Description : Directed self-checking bench for ref_block_loader. A second
//                instance built with CNT_W=2 shares all inputs and is used for
//                the counter wrap sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ref_block_loader;

`ifdef REF_LOADER_DOUBLE_BUF_EN
    localparam bit c_dbl = 1'b1;
`else
    localparam bit c_dbl = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [119:0]  in_row = '0;

    logic          in_ready, out_valid, out_sof;
    logic [1799:0] out_buffer;
    logic [15:0]   blk_cnt;
    logic          in_ready2, out_valid2, out_sof2;
    logic [1799:0] out_buffer2;
    logic [1:0]    blk_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ref_block_loader #(.PIX_W(8), .BLK(8), .TAPS(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_buffer(out_buffer), .out_sof(out_sof),
        .blk_cnt(blk_cnt)
    );

    ref_block_loader #(.PIX_W(8), .BLK(8), .TAPS(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_row(in_row), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_buffer(out_buffer2), .out_sof(out_sof2),
        .blk_cnt(blk_cnt2)
    );

    // Pixel (r,c) of window 'seed' is seed*37 + r*16 + c (mod 256).
    function automatic logic [119:0] row_of(input int seed, input int r);
        logic [119:0] v;
        for (int c = 0; c < 15; c++) v[c*8 +: 8] = 8'(seed*37 + r*16 + c);
        return v;
    endfunction

    function automatic logic [1799:0] win_of(input int seed);
        logic [1799:0] w;
        for (int r = 0; r < 15; r++) w[r*120 +: 120] = row_of(seed, r);
        return w;
    endfunction

    function automatic int first_diff(input logic [1799:0] a, input logic [1799:0] b);
        for (int k = 0; k < 225; k++) if (a[k*8 +: 8] !== b[k*8 +: 8]) return k;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic load_window(input int seed);
        for (int r = 0; r < 15; r++) begin
            in_valid = 1'b1;
            in_row   = row_of(seed, r);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [1799:0] zero = '0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL rst_sof got %0b exp 0", out_sof); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", in_ready); end
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", blk_cnt); end
        checks++; if (out_buffer !== zero) begin errors++; $display("FAIL rst_buf byte %0d nonzero", first_diff(out_buffer, zero)); end
        // out_ready with nothing to deliver must not count
        pop_one();
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL idle_ready_cnt got %0d exp 0", blk_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_valid got %0b exp 0", out_valid); end
    endtask

    task automatic check_first_window(input string tag);
        logic [1799:0] exp_w = win_of(0);
        logic          exp_rdy = c_dbl;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %0b exp 1", tag, out_valid); end
        checks++; if (out_sof !== 1'b1) begin errors++; $display("FAIL %s_sof got %0b exp 1", tag, out_sof); end
        checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL %s_ready got %0b exp %0b", tag, in_ready, exp_rdy); end
        checks++; if (out_buffer[7:0] !== 8'h00) begin errors++; $display("FAIL %s_px00 got %h exp 00", tag, out_buffer[7:0]); end
        checks++; if (out_buffer[1799:1792] !== 8'hEE) begin errors++; $display("FAIL %s_pxEE got %h exp ee", tag, out_buffer[1799:1792]); end
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL %s_cnt got %0d exp 0", tag, blk_cnt); end
        checks++; if (out_buffer !== exp_w) begin errors++; $display("FAIL %s_buf byte %0d got %h exp %h", tag, first_diff(out_buffer, exp_w), out_buffer[first_diff(out_buffer, exp_w)*8 +: 8], exp_w[first_diff(out_buffer, exp_w)*8 +: 8]); end
    endtask

    task automatic test_first_window();
        load_window(0);
        check_first_window("first");
    endtask

    task automatic test_hold();
        logic [1799:0] exp_w = win_of(0);
        logic          exp_rdy = c_dbl;
        // Single bank: a row offered while stalled must be ignored.
        if (!c_dbl) begin
            in_valid = 1'b1;
            in_row   = row_of(9, 0);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %0b exp 1", i, out_valid); end
            checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL hold_sof cyc %0d got %0b exp 0", i, out_sof); end
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL hold_ready cyc %0d got %0b exp %0b", i, in_ready, exp_rdy); end
            checks++; if (out_buffer !== exp_w) begin errors++; $display("FAIL hold_buf cyc %0d byte %0d", i, first_diff(out_buffer, exp_w)); end
        end
        in_valid = 1'b0;
        pop_one();
        checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL pop_cnt got %0d exp 1", blk_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_flush();
        logic [1799:0] exp_w;
        logic [119:0]  aa;
        for (int c = 0; c < 15; c++) aa[c*8 +: 8] = 8'hAA;
        for (int c = 0; c < 15; c++) exp_w[c*120 +: 120] = aa;
        for (int r = 0; r < 6; r++) begin
            in_valid = 1'b1; in_row = row_of(1, r); tick();
        end
        in_valid = 1'b1; flush = 1'b1; in_row = row_of(2, 0);
        tick();
        flush = 1'b0;
        for (int r = 0; r < 14; r++) begin
            in_valid = 1'b1; in_row = aa; tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid got %0b exp 0", out_valid); end
        in_valid = 1'b1; in_row = aa; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %0b exp 1", out_valid); end
        checks++; if (out_sof !== 1'b1) begin errors++; $display("FAIL flush_sof got %0b exp 1", out_sof); end
        checks++; if (out_buffer !== exp_w) begin errors++; $display("FAIL flush_buf byte %0d got %h exp aa", first_diff(out_buffer, exp_w), out_buffer[first_diff(out_buffer, exp_w)*8 +: 8]); end
        pop_one();
        checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", blk_cnt); end
    endtask

    task automatic test_async_reset();
        logic [1799:0] zero = '0;
        // mid-fill, reset asserted between clock edges
        for (int r = 0; r < 9; r++) begin
            in_valid = 1'b1; in_row = row_of(3, r); tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_fill_ready got %0b exp 1", in_ready); end
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL arst_fill_cnt got %0d exp 0", blk_cnt); end
        checks++; if (out_buffer !== zero) begin errors++; $display("FAIL arst_fill_buf byte %0d nonzero", first_diff(out_buffer, zero)); end
        tick();
        rst_n = 1'b1;
        // mid-hold
        load_window(4);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_hold_pre_valid got %0b exp 1", out_valid); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_hold_valid got %0b exp 0", out_valid); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL arst_hold_sof got %0b exp 0", out_sof); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_hold_ready got %0b exp 1", in_ready); end
        checks++; if (out_buffer !== zero) begin errors++; $display("FAIL arst_hold_buf byte %0d nonzero", first_diff(out_buffer, zero)); end
        tick();
        rst_n = 1'b1;
        load_window(0);
        check_first_window("reload");
        pop_one();
    endtask

    task automatic test_back_to_back();
        int rows_sent = 0;
        int delivered = 0;
        int bubbles = 0;
        int sofs = 0;
        int cyc = 0;
        int exp_bubbles;
        bit accepted;
        logic [1799:0] exp_w;
        exp_bubbles = c_dbl ? 0 : 2;
        do_reset();
        out_ready = 1'b1;
        while (delivered < 3 && cyc < 300) begin
            if (out_valid === 1'b1) begin
                exp_w = win_of(10 + delivered);
                checks++; if (out_buffer !== exp_w) begin errors++; $display("FAIL b2b_buf win %0d byte %0d", delivered, first_diff(out_buffer, exp_w)); end
                if (out_sof === 1'b1) sofs++;
                delivered++;
            end
            if (rows_sent < 45) begin
                in_valid = 1'b1;
                in_row   = row_of(10 + rows_sent / 15, rows_sent % 15);
                if (in_ready !== 1'b1) bubbles++;
            end else begin
                in_valid = 1'b0;
            end
            accepted = (rows_sent < 45) && (in_ready === 1'b1);
            tick();
            if (accepted) rows_sent++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (delivered != 3) begin errors++; $display("FAIL b2b_timeout delivered %0d exp 3", delivered); end
        checks++; if (blk_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt got %0d exp 3", blk_cnt); end
        checks++; if (sofs != 3) begin errors++; $display("FAIL b2b_sof got %0d exp 3", sofs); end
        checks++; if (bubbles != exp_bubbles) begin errors++; $display("FAIL b2b_bubbles got %0d exp %0d", bubbles, exp_bubbles); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %0b exp 0", out_valid); end
    endtask

    task automatic test_cnt_wrap();
        int exp_seq [5] = '{1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            load_window(20 + k);
            pop_one();
            checks++; if (blk_cnt2 !== 2'(exp_seq[k])) begin errors++; $display("FAIL wrap_cnt2 win %0d got %0d exp %0d", k, blk_cnt2, exp_seq[k]); end
            checks++; if (blk_cnt !== 16'(k + 1)) begin errors++; $display("FAIL wrap_cnt16 win %0d got %0d exp %0d", k, blk_cnt, k + 1); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_window();
        test_hold();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
